// File: rtl/seg_anim_pkg.sv
// rtl/seg_anim_pkg.sv - shared constants and pattern helpers for the segment animator
package seg_anim_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] INIT_PAT [4] = '{6'b111110, 6'b011111, 6'b000001, 6'b100000};

  function automatic logic [7:0] init_pat(input int unsigned idx);
    return {2'b00, INIT_PAT[2'(idx % 4)]};
  endfunction

  // Rotate the low w bits of p by one position; bits above w come back as 0.
  function automatic logic [7:0] rotate_pat(input logic [7:0] p, input logic [3:0] w,
                                            input logic right);
    logic [7:0] mask;
    logic [7:0] q;
    mask = 8'hFF >> (4'd8 - w);
    q    = p & mask;
    if (right) return ((q >> 1) | (q << (w - 4'd1))) & mask;
    else       return ((q << 1) | (q >> (w - 4'd1))) & mask;
  endfunction

  function automatic logic [7:0] pad_seg(input logic [7:0] p, input logic [3:0] w);
    return p | ~(8'hFF >> (4'd8 - w));
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - enable-gated modulo-DIV counter producing a one-cycle tick on wrap
module seg_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_anim_scan.sv
// rtl/seg_anim_scan.sv - multiplexed display scanner with per-digit rotating segment patterns
module seg_anim_scan
  import seg_anim_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_W   = 3,
  parameter int SCAN_DIV = 65536,
  parameter int STEP_DIV = 12500000,
  parameter int RING_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DIGITS-1:0] dir,
  input  logic              load,
  input  logic [SCAN_W-1:0] load_idx,
  input  logic [RING_W-1:0] load_pat,
  output logic [7:0]        segout,
  output logic [SCAN_W-1:0] scanout,
  output logic              step
);

  localparam logic [3:0] RW = 4'(RING_W);

  logic              scan_tick;
  logic              step_tick;
  logic              load_ok;
  logic [RING_W-1:0] pat     [DIGITS];
  logic [RING_W-1:0] pat_rot [DIGITS];
  logic [RING_W-1:0] pat_cur;

  seg_tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .tick  (scan_tick)
  );

  seg_tick_gen #(.DIV(STEP_DIV)) u_step_div (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .tick  (step_tick)
  );

  assign step    = step_tick;
  assign load_ok = load && (int'(load_idx) < DIGITS);

  always_comb begin
    pat_cur = pat[0];
    for (int i = 0; i < DIGITS; i++) begin
      pat_rot[i] = RING_W'(rotate_pat(8'(pat[i]), RW, dir[i]));
      if (scanout == SCAN_W'(i)) pat_cur = pat[i];
    end
  end

  // A load wins over rotation for its own digit only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++) pat[i] <= RING_W'(init_pat(i));
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (load_ok && (load_idx == SCAN_W'(i))) pat[i] <= load_pat;
        else if (step_tick)                      pat[i] <= pat_rot[i];
      end
    end
  end

  // The first cycle of every slot is blanked so the old digit never ghosts onto the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scanout <= '0;
      segout  <= SEG_BLANK;
    end else if (scan_tick) begin
      scanout <= (scanout == SCAN_W'(DIGITS - 1)) ? '0 : scanout + 1'b1;
      segout  <= SEG_BLANK;
    end else begin
      segout  <= pad_seg(8'(pat_cur), RW);
    end
  end

endmodule

// File: tb/tb_seg_anim_scan.sv
// tb/tb_seg_anim_scan.sv - directed self-checking bench for seg_anim_scan
module tb_seg_anim_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [3:0] dir = 4'h0;
  logic       load = 1'b0;
  logic [2:0] load_idx = 3'd0;
  logic [5:0] load_pat = 6'd0;
  logic [7:0] segout;
  logic [2:0] scanout;
  logic       step;

  int checks = 0;
  int passed = 0;

  logic [7:0] p1_seg [9] = '{8'hFE, 8'hFF, 8'hDF, 8'hFF, 8'hC1, 8'hFF, 8'hE0, 8'hFF, 8'hFE};
  logic [2:0] p1_sc  [9] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};
  logic [7:0] p2_seg [9] = '{8'hFE, 8'hDF, 8'hC2, 8'hC1, 8'hFB, 8'hFD, 8'hC8, 8'hC4, 8'hEF};
  logic [7:0] p3_seg [6] = '{8'hFE, 8'hDF, 8'hE0, 8'hD0, 8'hEF, 8'hF7};

  always #5 clk = ~clk;

  seg_anim_scan #(
    .DIGITS   (4),
    .SCAN_W   (3),
    .SCAN_DIV (2),
    .STEP_DIV (4),
    .RING_W   (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .dir      (dir),
    .load     (load),
    .load_idx (load_idx),
    .load_pat (load_pat),
    .segout   (segout),
    .scanout  (scanout),
    .step     (step)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic run_v, input logic [3:0] dir_v);
    reset = 1'b0;
    run   = run_v;
    dir   = dir_v;
    load  = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    tick();
    check("rst_seg", segout, 8'hFF);
    check("rst_sc", scanout, 3'd0);
    check("rst_step", step, 1'b0);

    // frozen patterns, scan cadence and blanking
    restart(1'b0, 4'h0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      check($sformatf("p1_seg_n%0d", n), segout, p1_seg[n-1]);
      check($sformatf("p1_sc_n%0d", n), scanout, p1_sc[n-1]);
      check($sformatf("p1_step_n%0d", n), step, 1'b0);
    end

    // rotate left on every digit
    restart(1'b1, 4'h0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      check($sformatf("p2_step_n%0d", n), step, (n % 4) == 3);
      if (n % 2 == 1) check($sformatf("p2_seg_n%0d", n), segout, p2_seg[(n-1)/2]);
      else            check($sformatf("p2_seg_n%0d", n), segout, 8'hFF);
    end

    // rotate right on every digit
    restart(1'b1, 4'hF);
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n % 2 == 1) check($sformatf("p3_seg_n%0d", n), segout, p3_seg[(n-1)/2]);
    end

    // loads: coinciding with a step, out of range, and between steps
    restart(1'b1, 4'h0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      case (n)
        3: begin
          check("p4_step_n3", step, 1'b1);
          load = 1'b1; load_idx = 3'd2; load_pat = 6'b010101;
        end
        4:  load = 1'b0;
        5:  check("p4_load_step_d2", segout, 8'hD5);
        7: begin
          check("p4_rot_d3", segout, 8'hC1);
          load = 1'b1; load_idx = 3'd5; load_pat = 6'b000000;
        end
        8:  load = 1'b0;
        9: begin
          check("p4_d0_n9", segout, 8'hFB);
          load = 1'b1; load_idx = 3'd0; load_pat = 6'b000111;
        end
        10: load = 1'b0;
        11: check("p4_ignored_d1", segout, 8'hFD);
        13: check("p4_d2_n13", segout, 8'hD5);
        15: check("p4_d3_n15", segout, 8'hC4);
        17: check("p4_load_d0", segout, 8'hDC);
        default: ;
      endcase
    end

    // pause run mid-count; scan timing must not move
    restart(1'b1, 4'h0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n >= 3) check($sformatf("p5_step_n%0d", n), step, (n == 13) || (n == 17));
      check($sformatf("p5_sc_n%0d", n), scanout, 3'((n / 2) % 4));
      if (n == 2)  run = 1'b0;
      if (n == 12) run = 1'b1;
      if (n == 7)  check("p5_frozen_d3", segout, 8'hE0);
      if (n == 15) check("p5_resumed_d3", segout, 8'hC1);
      if (n == 17) check("p5_resumed_d0", segout, 8'hFD);
    end

    // asynchronous reset in the middle of a step pulse
    #1;
    reset = 1'b0;
    #1;
    check("p6_async_seg", segout, 8'hFF);
    check("p6_async_sc", scanout, 3'd0);
    check("p6_async_step", step, 1'b0);
    #1;
    reset = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (n == 1) check("p6_d0_init", segout, 8'hFE);
      if (n == 3) begin
        check("p6_d1_init", segout, 8'hDF);
        check("p6_step_n3", step, 1'b1);
      end
      if (n == 5) check("p6_d2_rot", segout, 8'hC2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
